match_control: RTL

- Parametrised successor to the two-player game-mode FSM: it runs a multi-player, multi-round match.
- Handles a lobby join phase, a timed pre-round countdown, elimination-based rounds with draw detection, per-player score keeping, first-to-WIN_ROUNDS match end, and a click-to-restart screen.
- Sits between the input sources (mouse, UART players, collision detectors) and the draw/game-logic blocks, which consume mode and player status.

---
 rtl/game_pkg.sv | 12 +
 rtl/vga_pkg.sv | 14 +
 rtl/tick_timer.sv | 54 +++++
 rtl/match_control.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Match-level types shared by the match controller and its consumers.
package game_pkg;

  typedef enum logic [2:0] {
    LOBBY      = 3'd0,
    COUNTDOWN  = 3'd1,
    PLAY       = 3'd2,
    ROUND_OVER = 3'd3,
    MATCH_OVER = 3'd4
  } match_mode_t;

endpackage

// File: rtl/vga_pkg.sv
// Screen-space button bounds used for mouse hit testing (exclusive edges).
package vga_pkg;

  localparam logic [11:0] PLAY_X_MIN = 12'd412;
  localparam logic [11:0] PLAY_X_MAX = 12'd612;
  localparam logic [11:0] PLAY_Y_MIN = 12'd300;
  localparam logic [11:0] PLAY_Y_MAX = 12'd380;

  localparam logic [11:0] RECT_X_MIN = 12'd412;
  localparam logic [11:0] RECT_X_MAX = 12'd612;
  localparam logic [11:0] RECT_Y_MIN = 12'd450;
  localparam logic [11:0] RECT_Y_MAX = 12'd530;

endpackage

// File: rtl/tick_timer.sv
// Prescaler plus tick down-counter; one instance serves both the pre-round
// countdown and the post-round pause.
module tick_timer #(
  parameter int TICK_CYCLES = 65_000_000,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tick_o,
  output logic             done_o
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o  = en_i && (pre_q == PRE_LAST);
  // Level flag: the current tick period is the last one, so tick_o ends it.
  assign done_o  = (cnt_q == CNT_W'(1));
  assign count_o = cnt_q;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load_i) begin
      pre_d = '0;
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/match_control.sv
// Multi-player match controller: lobby, timed countdown, elimination rounds,
// score keeping, match end and click-to-restart.
module match_control
  import game_pkg::*;
  import vga_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int MIN_PLAYERS     = 2,
  parameter int WIN_ROUNDS      = 3,
  parameter int SCORE_W         = 4,
  parameter int TICK_CYCLES     = 65_000_000,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int PAUSE_TICKS     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mouse_left,
  input  logic [11:0]                    xpos,
  input  logic [11:0]                    ypos,
  input  logic [NUM_PLAYERS-1:0]         join_req,
  input  logic [NUM_PLAYERS-1:0]         collision,
  output match_mode_t                    mode,
  output logic [NUM_PLAYERS-1:0]         joined,
  output logic [NUM_PLAYERS-1:0]         alive,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [3:0]                     countdown,
  output logic                           round_start,
  output logic [NUM_PLAYERS-1:0]         round_winner,
  output logic [NUM_PLAYERS-1:0]         match_winner
);

  localparam logic [SCORE_W-1:0] SW_WIN = SCORE_W'(WIN_ROUNDS);

  function automatic int popcount(input logic [NUM_PLAYERS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_PLAYERS; i++) n += int'(v[i]);
    return n;
  endfunction

  match_mode_t                    mode_q, mode_d;
  logic [NUM_PLAYERS-1:0]         joined_q, joined_d;
  logic [NUM_PLAYERS-1:0]         alive_q, alive_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] score_q, score_d;
  logic                           round_start_q, round_start_d;
  logic [NUM_PLAYERS-1:0]         round_winner_q, round_winner_d;
  logic [NUM_PLAYERS-1:0]         match_winner_q, match_winner_d;
  logic                           mouse_left_q;

  logic                           click, in_play, in_rect;
  logic [NUM_PLAYERS-1:0]         alive_nxt;
  int                             survivors;
  logic [NUM_PLAYERS*SCORE_W-1:0] score_won;
  logic [NUM_PLAYERS-1:0]         hit_win;

  logic       tmr_load, tmr_en, tmr_tick, tmr_done;
  logic [3:0] tmr_val, tmr_count;

  assign click   = mouse_left & ~mouse_left_q;
  assign in_play = (xpos > PLAY_X_MIN) && (xpos < PLAY_X_MAX) &&
                   (ypos > PLAY_Y_MIN) && (ypos < PLAY_Y_MAX);
  assign in_rect = (xpos > RECT_X_MIN) && (xpos < RECT_X_MAX) &&
                   (ypos > RECT_Y_MIN) && (ypos < RECT_Y_MAX);

  assign alive_nxt = alive_q & ~(collision & joined_q);
  assign survivors = popcount(alive_nxt);

  // Candidate scores if the sole survivor is credited; saturates at WIN_ROUNDS.
  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score
    logic [SCORE_W-1:0] cur, inc;
    assign cur = score_q[gi*SCORE_W +: SCORE_W];
    assign inc = (cur < SW_WIN) ? cur + SCORE_W'(1) : cur;
    assign score_won[gi*SCORE_W +: SCORE_W] = alive_nxt[gi] ? inc : cur;
    assign hit_win[gi] = alive_nxt[gi] && (inc == SW_WIN);
  end

  tick_timer #(
    .TICK_CYCLES(TICK_CYCLES),
    .CNT_W      (4)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .en_i      (tmr_en),
    .count_o   (tmr_count),
    .tick_o    (tmr_tick),
    .done_o    (tmr_done)
  );

  always_comb begin
    mode_d         = mode_q;
    joined_d       = joined_q;
    alive_d        = alive_q;
    score_d        = score_q;
    round_start_d  = 1'b0;
    round_winner_d = round_winner_q;
    match_winner_d = match_winner_q;
    tmr_load       = 1'b0;
    tmr_en         = 1'b0;
    tmr_val        = 4'(COUNTDOWN_TICKS);

    unique case (mode_q)
      LOBBY: begin
        joined_d = joined_q | join_req;
        if ((&joined_q) ||
            (click && in_play && (popcount(joined_q) >= MIN_PLAYERS))) begin
          mode_d   = COUNTDOWN;
          alive_d  = joined_d;
          tmr_load = 1'b1;
        end
      end
      COUNTDOWN: begin
        tmr_en = 1'b1;
        if (tmr_tick && tmr_done) begin
          mode_d         = PLAY;
          round_start_d  = 1'b1;
          round_winner_d = '0;
        end
      end
      PLAY: begin
        alive_d = alive_nxt;
        if (survivors <= 1) begin
          tmr_load = 1'b1;
          tmr_val  = 4'(PAUSE_TICKS);
          mode_d   = ROUND_OVER;
          if (survivors == 1) begin
            score_d        = score_won;
            round_winner_d = alive_nxt;
            if (|hit_win) begin
              mode_d         = MATCH_OVER;
              match_winner_d = alive_nxt;
            end
          end else begin
            round_winner_d = '0;
          end
        end
      end
      ROUND_OVER: begin
        tmr_en = 1'b1;
        if (tmr_tick && tmr_done) begin
          mode_d   = COUNTDOWN;
          alive_d  = joined_q;
          tmr_load = 1'b1;
        end
      end
      MATCH_OVER: begin
        if (click && in_rect) begin
          mode_d         = LOBBY;
          joined_d       = '0;
          alive_d        = '0;
          score_d        = '0;
          round_winner_d = '0;
          match_winner_d = '0;
        end
      end
      default: mode_d = LOBBY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q         <= LOBBY;
      joined_q       <= '0;
      alive_q        <= '0;
      score_q        <= '0;
      round_start_q  <= 1'b0;
      round_winner_q <= '0;
      match_winner_q <= '0;
      mouse_left_q   <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      joined_q       <= joined_d;
      alive_q        <= alive_d;
      score_q        <= score_d;
      round_start_q  <= round_start_d;
      round_winner_q <= round_winner_d;
      match_winner_q <= match_winner_d;
      mouse_left_q   <= mouse_left;
    end
  end

  assign mode         = mode_q;
  assign joined       = joined_q;
  assign alive        = alive_q;
  assign score        = score_q;
  assign countdown    = (mode_q == COUNTDOWN) ? tmr_count : 4'd0;
  assign round_start  = round_start_q;
  assign round_winner = round_winner_q;
  assign match_winner = match_winner_q;

endmodule
